// File: rtl/game_sequencer.sv
// Front-end controller for the five-in-a-row board: debounces the keys, sequences
// the choose/put/turn strobes for the datapath and locks the board on win or draw.
module game_sequencer #(
   parameter int DEB_CYCLES  = 16,
   parameter int PUT_CYCLES  = 4,
   parameter int CLR_CYCLES  = 2,
   parameter int BOARD_CELLS = 256
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_put,
   input  logic       key_right,
   input  logic       key_down,
   input  logic       key_new,
   input  logic       write_enable,
   input  logic [1:0] check_ans,
   output logic       put,
   output logic       right,
   output logic       down,
   output logic       turn_control,
   output logic       change_able_read,
   output logic       control_set,
   output logic       reject,
   output logic       game_over,
   output logic       draw,
   output logic [8:0] move_count
);

   localparam int          KEYS     = 4;
   localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
   localparam logic [7:0]  PUT_LAST = 8'(PUT_CYCLES - 1);
   localparam logic [7:0]  CLR_LAST = 8'(CLR_CYCLES - 1);
   localparam logic [8:0]  CELLS    = 9'(BOARD_CELLS);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_CHOICE, S_PUT, S_SETTLE, S_TURN, S_RELEASE, S_OVER
   } state_t;

   state_t      state, state_next;
   logic [7:0]  cnt, cnt_next;
   logic [8:0]  count_next;
   logic        draw_next;

   logic [KEYS-1:0] key_raw;
   logic [KEYS-1:0] sync_p0, sync_p1;
   logic [KEYS-1:0] stable, press_p2;
   logic [15:0]     deb_cnt [KEYS];
   logic            right_p3, down_p3, turn_p1;

   logic put_ev, new_ev;

   // bit order: 0 put, 1 right, 2 down, 3 new
   assign key_raw = {key_new, key_down, key_right, key_put};

   // stage p0/p1: two-flop synchroniser on the raw buttons
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= key_raw;
         sync_p1 <= sync_p0;
      end
   end

   // stage p2: debouncer, press_p2 pulses on the accepted 0->1 transition
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stable   <= '0;
         press_p2 <= '0;
         for (int k = 0; k < KEYS; k++) deb_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < KEYS; k++) begin
            press_p2[k] <= 1'b0;
            if (sync_p1[k] == stable[k]) begin
               deb_cnt[k] <= '0;
            end else if (deb_cnt[k] == DEB_LAST) begin
               stable[k]   <= sync_p1[k];
               press_p2[k] <= sync_p1[k];
               deb_cnt[k]  <= '0;
            end else begin
               deb_cnt[k] <= deb_cnt[k] + 16'd1;
            end
         end
      end
   end

   assign put_ev = press_p2[0];
   assign new_ev = press_p2[3];

   // stage p3: move events and the turn strobe, one register behind their source
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         right_p3 <= 1'b0;
         down_p3  <= 1'b0;
         turn_p1  <= 1'b0;
      end else begin
         right_p3 <= press_p2[1];
         down_p3  <= press_p2[2];
         turn_p1  <= (state == S_TURN);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_INIT;
         cnt        <= '0;
         move_count <= '0;
         draw       <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         move_count <= count_next;
         draw       <= draw_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      count_next = move_count;
      draw_next  = draw;
      case (state)
         S_INIT: begin
            if (cnt == CLR_LAST) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         S_IDLE: begin
            if (new_ev) begin
               state_next = S_INIT;
               cnt_next   = '0;
               count_next = '0;
               draw_next  = 1'b0;
            end else if (put_ev) begin
               state_next = S_CHOICE;
            end
         end
         S_CHOICE: begin
            cnt_next   = '0;
            state_next = write_enable ? S_PUT : S_RELEASE;
         end
         S_PUT: begin
            if (cnt == PUT_LAST) begin
               state_next = S_SETTLE;
               cnt_next   = '0;
               if (move_count != CELLS) count_next = move_count + 9'd1;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         S_SETTLE: state_next = S_TURN;
         S_TURN: begin
            if (check_ans != 2'b00) begin
               state_next = S_OVER;
            end else if (move_count == CELLS) begin
               state_next = S_OVER;
               draw_next  = 1'b1;
            end else begin
               state_next = S_RELEASE;
            end
         end
         S_RELEASE: if (!stable[0]) state_next = S_IDLE;
         S_OVER: begin
            if (new_ev) begin
               state_next = S_INIT;
               cnt_next   = '0;
               count_next = '0;
               draw_next  = 1'b0;
            end
         end
         default: state_next = S_INIT;
      endcase
   end

   // control_set is masked while reset is held so every output reads 0 during reset
   assign control_set      = (state == S_INIT) & ~reset;
   assign change_able_read = (state == S_CHOICE);
   assign reject           = (state == S_CHOICE) & ~write_enable;
   assign put              = (state == S_PUT);
   assign game_over        = (state == S_OVER);
   assign turn_control     = turn_p1;
   assign right            = right_p3 & (state == S_IDLE);
   assign down             = down_p3 & (state == S_IDLE);

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus randomized
// transactions checked against a transaction-level model of the game rules.
module tb_game_sequencer;

   localparam int DEB   = 16;
   localparam int PUTC  = 4;
   localparam int CLR   = 2;
   localparam int CELLS = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       key_put = 1'b0, key_right = 1'b0, key_down = 1'b0, key_new = 1'b0;
   logic       write_enable = 1'b0;
   logic [1:0] check_ans = 2'b00;
   logic       put, right, down, turn_control, change_able_read, control_set;
   logic       reject, game_over, draw;
   logic [8:0] move_count;

   always #5 clock = ~clock;

   game_sequencer #(
      .DEB_CYCLES(DEB), .PUT_CYCLES(PUTC), .CLR_CYCLES(CLR), .BOARD_CELLS(CELLS)
   ) dut (
      .clock(clock), .reset(reset),
      .key_put(key_put), .key_right(key_right), .key_down(key_down), .key_new(key_new),
      .write_enable(write_enable), .check_ans(check_ans),
      .put(put), .right(right), .down(down), .turn_control(turn_control),
      .change_able_read(change_able_read), .control_set(control_set), .reject(reject),
      .game_over(game_over), .draw(draw), .move_count(move_count)
   );

   int vec = 0, errs = 0;

   // pulse monitor, sampled on the falling edge; cleared by bumping epoch
   int epoch = 0, seen = 0, cyc = 0;
   int n_put, n_car, n_turn, n_rej, n_cs, n_right, n_right_rise, n_down, n_down_rise;
   int put_rise_at, car_at, turn_at;
   logic put_q = 1'b0, right_q = 1'b0, down_q = 1'b0;

   always @(negedge clock) begin
      cyc++;
      if (epoch != seen) begin
         seen = epoch;
         n_put = 0; n_car = 0; n_turn = 0; n_rej = 0; n_cs = 0;
         n_right = 0; n_right_rise = 0; n_down = 0; n_down_rise = 0;
         put_rise_at = -100; car_at = -100; turn_at = -100;
      end
      if (put) n_put++;
      if (put && !put_q) put_rise_at = cyc;
      if (change_able_read) begin n_car++; car_at = cyc; end
      if (turn_control) begin n_turn++; turn_at = cyc; end
      if (reject) n_rej++;
      if (control_set) n_cs++;
      if (right) n_right++;
      if (right && !right_q) n_right_rise++;
      if (down) n_down++;
      if (down && !down_q) n_down_rise++;
      put_q = put; right_q = right; down_q = down;
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic clear_mon();
      epoch++;
   endtask

   // mask bits: 0 put, 1 right, 2 down, 3 new
   task automatic keys(input logic [3:0] m);
      {key_new, key_down, key_right, key_put} = m;
   endtask

   task automatic press(input logic [3:0] m, input int hold);
      keys(m);
      repeat (hold) tick();
      keys(4'b0000);
      repeat (40) tick();
   endtask

   task automatic test_reset();
      keys(4'b0000);
      repeat (3) tick();
      vec++;
      if ({put, right, down, turn_control, change_able_read, control_set, reject,
           game_over, draw, move_count} !== 18'd0) begin
         errs++;
         $display("FAIL reset_outputs: got put=%b cs=%b go=%b cnt=%0d, want all 0",
                  put, control_set, game_over, move_count);
      end
      clear_mon();
      reset = 1'b0;
      repeat (10) tick();
      vec++;
      if (n_cs !== CLR) begin
         errs++; $display("FAIL reset_control_set: got %0d cycles, want %0d", n_cs, CLR);
      end
      vec++;
      if (n_put + n_car + n_turn + n_rej + n_right + n_down !== 0 || game_over !== 1'b0 ||
          draw !== 1'b0 || move_count !== 9'd0) begin
         errs++;
         $display("FAIL reset_idle: pulses=%0d go=%b draw=%b cnt=%0d, want 0",
                  n_put + n_car + n_turn + n_rej + n_right + n_down, game_over, draw, move_count);
      end
   endtask

   task automatic test_glitch();
      write_enable = 1'b1; check_ans = 2'b00;
      clear_mon();
      keys(4'b0001);
      repeat (10) tick();
      keys(4'b0000);
      repeat (40) tick();
      vec++;
      if (n_car !== 0 || n_put !== 0) begin
         errs++; $display("FAIL glitch: got car=%0d put=%0d, want 0 0", n_car, n_put);
      end
   endtask

   task automatic test_valid_put();
      write_enable = 1'b1; check_ans = 2'b00;
      clear_mon();
      press(4'b0001, 40);
      vec++;
      if (n_car !== 1 || n_put !== PUTC || n_turn !== 1 || n_rej !== 0) begin
         errs++;
         $display("FAIL valid_put_pulses: car=%0d put=%0d turn=%0d rej=%0d, want 1 %0d 1 0",
                  n_car, n_put, n_turn, n_rej, PUTC);
      end
      vec++;
      if (put_rise_at - car_at !== 1 || turn_at - put_rise_at !== PUTC + 2) begin
         errs++;
         $display("FAIL valid_put_timing: car->put=%0d put->turn=%0d, want 1 %0d",
                  put_rise_at - car_at, turn_at - put_rise_at, PUTC + 2);
      end
      vec++;
      if (move_count !== 9'd1) begin
         errs++; $display("FAIL valid_put_count: got %0d, want 1", move_count);
      end
   endtask

   task automatic test_reject();
      write_enable = 1'b0; check_ans = 2'b00;
      clear_mon();
      press(4'b0001, 100);
      vec++;
      if (n_car !== 1 || n_rej !== 1 || n_put !== 0 || n_turn !== 0) begin
         errs++;
         $display("FAIL reject: car=%0d rej=%0d put=%0d turn=%0d, want 1 1 0 0",
                  n_car, n_rej, n_put, n_turn);
      end
      vec++;
      if (move_count !== 9'd1) begin
         errs++; $display("FAIL reject_count: got %0d, want 1", move_count);
      end
   endtask

   task automatic test_moves();
      clear_mon();
      press(4'b0110, 40);
      vec++;
      if (n_right !== 1 || n_right_rise !== 1 || n_down !== 1 || n_down_rise !== 1) begin
         errs++;
         $display("FAIL moves: right=%0d/%0d down=%0d/%0d, want 1/1 1/1",
                  n_right, n_right_rise, n_down, n_down_rise);
      end
      // right pressed two cycles after put so its event lands while put is high
      write_enable = 1'b1; check_ans = 2'b00;
      clear_mon();
      keys(4'b0001);
      repeat (2) tick();
      keys(4'b0011);
      repeat (40) tick();
      keys(4'b0000);
      repeat (40) tick();
      vec++;
      if (n_right !== 0 || n_put !== PUTC || move_count !== 9'd2) begin
         errs++;
         $display("FAIL move_in_put: right=%0d put=%0d cnt=%0d, want 0 %0d 2",
                  n_right, n_put, move_count, PUTC);
      end
   endtask

   task automatic test_win();
      write_enable = 1'b1; check_ans = 2'b01;
      press(4'b0001, 40);
      vec++;
      if (game_over !== 1'b1 || draw !== 1'b0 || move_count !== 9'd3) begin
         errs++;
         $display("FAIL win: go=%b draw=%b cnt=%0d, want 1 0 3", game_over, draw, move_count);
      end
      check_ans = 2'b00;
      clear_mon();
      press(4'b0011, 40);
      press(4'b0100, 40);
      vec++;
      if (n_car !== 0 || n_put !== 0 || n_right !== 0 || n_down !== 0 || game_over !== 1'b1) begin
         errs++;
         $display("FAIL over_locked: car=%0d put=%0d right=%0d down=%0d go=%b, want 0 0 0 0 1",
                  n_car, n_put, n_right, n_down, game_over);
      end
      clear_mon();
      press(4'b1000, 40);
      vec++;
      if (n_cs !== CLR || move_count !== 9'd0 || game_over !== 1'b0) begin
         errs++;
         $display("FAIL new_game: cs=%0d cnt=%0d go=%b, want %0d 0 0",
                  n_cs, move_count, game_over, CLR);
      end
   endtask

   task automatic test_draw();
      write_enable = 1'b1; check_ans = 2'b00;
      press(4'b0001, 40);
      press(4'b0001, 40);
      vec++;
      if (game_over !== 1'b0 || move_count !== 9'd2) begin
         errs++; $display("FAIL pre_draw: go=%b cnt=%0d, want 0 2", game_over, move_count);
      end
      press(4'b0001, 40);
      vec++;
      if (draw !== 1'b1 || game_over !== 1'b1 || move_count !== 9'd3) begin
         errs++;
         $display("FAIL draw: draw=%b go=%b cnt=%0d, want 1 1 3", draw, game_over, move_count);
      end
      press(4'b1000, 40);
      vec++;
      if (draw !== 1'b0 || game_over !== 1'b0 || move_count !== 9'd0) begin
         errs++;
         $display("FAIL draw_clear: draw=%b go=%b cnt=%0d, want 0 0 0", draw, game_over, move_count);
      end
   endtask

   task automatic test_reset_mid_put();
      int k;
      write_enable = 1'b1; check_ans = 2'b00;
      keys(4'b0001);
      k = 0;
      while (put !== 1'b1 && k < 60) begin
         tick();
         k++;
      end
      vec++;
      if (put !== 1'b1) begin
         errs++; $display("FAIL mid_put_wait: put=%b after %0d cycles, want 1", put, k);
      end
      #2;
      reset = 1'b1;
      keys(4'b0000);
      #1;
      vec++;
      if (put !== 1'b0 || control_set !== 1'b0 || move_count !== 9'd0) begin
         errs++;
         $display("FAIL mid_put_reset: put=%b cs=%b cnt=%0d, want 0 0 0", put, control_set, move_count);
      end
      tick();
      clear_mon();
      reset = 1'b0;
      repeat (40) tick();
      vec++;
      if (n_cs !== CLR || n_put !== 0 || n_car !== 0) begin
         errs++;
         $display("FAIL mid_put_recover: cs=%0d put=%0d car=%0d, want %0d 0 0", n_cs, n_put, n_car, CLR);
      end
   endtask

   task automatic test_random();
      int m_count, m_over, m_draw;
      int e_car, e_put, e_turn, e_rej, e_r, e_d, e_cs, sel;
      logic [3:0] m;
      logic [1:0] rd;
      m_count = 0; m_over = 0; m_draw = 0;
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         write_enable = ($urandom_range(0, 3) != 0);
         check_ans = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         e_car = 0; e_put = 0; e_turn = 0; e_rej = 0; e_r = 0; e_d = 0; e_cs = 0;
         if (sel <= 5) begin
            m = 4'b0001;
            if (m_over == 0) begin
               e_car = 1;
               if (write_enable) begin
                  e_put = PUTC; e_turn = 1;
                  if (m_count < CELLS) m_count++;
                  if (check_ans != 2'b00) m_over = 1;
                  else if (m_count == CELLS) begin m_over = 1; m_draw = 1; end
               end else begin
                  e_rej = 1;
               end
            end
         end else if (sel <= 8) begin
            rd = 2'($urandom_range(1, 3));
            m = {1'b0, rd, 1'b0};
            if (m_over == 0) begin e_r = int'(rd[0]); e_d = int'(rd[1]); end
         end else begin
            m = 4'b1000;
            e_cs = CLR; m_count = 0; m_over = 0; m_draw = 0;
         end
         clear_mon();
         press(m, 40);
         vec++;
         if (n_car !== e_car || n_put !== e_put || n_turn !== e_turn || n_rej !== e_rej ||
             n_right !== e_r || n_down !== e_d || n_cs !== e_cs) begin
            errs++;
            $display("FAIL rand_pulses[%0d]: car/put/turn/rej/r/d/cs got %0d/%0d/%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d/%0d/%0d",
                     i, n_car, n_put, n_turn, n_rej, n_right, n_down, n_cs,
                     e_car, e_put, e_turn, e_rej, e_r, e_d, e_cs);
         end
         vec++;
         if ({move_count, game_over, draw} !== {9'(m_count), m_over[0], m_draw[0]}) begin
            errs++;
            $display("FAIL rand_status[%0d]: cnt/go/draw got %0d/%b/%b want %0d/%0d/%0d",
                     i, move_count, game_over, draw, m_count, m_over, m_draw);
         end
         if (e_put != 0) begin
            vec++;
            if (put_rise_at - car_at !== 1 || turn_at - put_rise_at !== PUTC + 2) begin
               errs++;
               $display("FAIL rand_timing[%0d]: car->put=%0d put->turn=%0d want 1 %0d",
                        i, put_rise_at - car_at, turn_at - put_rise_at, PUTC + 2);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_valid_put();
      test_reject();
      test_moves();
      test_win();
      test_draw();
      test_reset_mid_put();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
